// File: rtl/uart_arb_pkg.sv
// Purpose: shared FSM encoding and sizing helper for the uart_tx round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_arb_pkg;

    typedef logic [1:0] arb_state_t;

    // Fixed encodings so existing state decoders and probes keep working.
    localparam arb_state_t IDLE      = 2'd0;
    localparam arb_state_t START     = 2'd1;
    localparam arb_state_t WAIT_DONE = 2'd2;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: combinational round-robin pick of the first set request at or after a pointer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports:
//   req      requests, one bit per requester
//   pointer  highest-priority index this round
//   valid    any request set
//   index    chosen requester (0 when valid is low)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set request
    // (lowest offset from pointer) is the last and winning assignment.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(pointer) + off) % NUM_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin sharing of one uart_tx between NUM_REQ byte requesters.
// Latency: req -> grant 1 cycle; grant -> uart_start 1 cycle; uart_done -> next grant 2 cycles.
// Backpressure: holds each byte until uart_tx reports done; requests wait while busy.
//
// Ports:
//   clk, reset           clock and synchronous active-low reset
//   req, req_data        per-requester level request and byte lane
//   grant, done          one-cycle pulses: byte captured / byte sent
//   owner, arb_busy      current/last owner, transfer in progress
//   uart_start/data      to uart_tx; uart_busy/uart_done from uart_tx
//   timeout_err          watchdog abort pulse
// Optional watchdog: define UART_ARB_TIMEOUT_EN (otherwise timeout_err stays 0).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = 8,
    parameter  int TIMEOUT_CYC = 4096,
    localparam int IDX_W       = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [IDX_W-1:0]          owner,
    output logic                      arb_busy,
    output logic                      uart_start,
    output logic [DATA_W-1:0]         uart_data,
    input  logic                      uart_busy,
    input  logic                      uart_done,
    output logic                      timeout_err
);

    arb_state_t        state;
    logic [IDX_W-1:0]  pointer;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] pick_dat;
    logic [IDX_W-1:0]  next_ptr;
    logic              wd_fire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .pointer (pointer),
        .valid   (pick_vld),
        .index   (pick_idx)
    );

    always_comb begin
        pick_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_dat = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wd_cnt;

    // Held at zero in IDLE, so it starts from zero on every entry to START.
    always_ff @(posedge clk) begin
        if (!reset || state == IDLE) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A completion arriving on the expiry cycle wins over the abort.
    assign wd_fire = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) &&
                     !(state == WAIT_DONE && uart_done);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pointer     <= '0;
            owner       <= '0;
            uart_data   <= '0;
            grant       <= '0;
            done        <= '0;
            arb_busy    <= 1'b0;
            uart_start  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        uart_data <= pick_dat;
                        owner     <= pick_idx;
                        grant     <= NUM_REQ'(1) << pick_idx;
                        arb_busy  <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    // Registered start: rises the cycle after grant, drops on the
                    // edge where uart_tx reports busy.
                    if (uart_busy) begin
                        uart_start <= 1'b0;
                        state      <= WAIT_DONE;
                    end else begin
                        uart_start <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    uart_start <= 1'b0;
                    if (uart_done) begin
                        done     <= NUM_REQ'(1) << owner;
                        pointer  <= next_ptr;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    uart_start <= 1'b0;
                    arb_busy   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
            if (wd_fire) begin
                timeout_err <= 1'b1;
                uart_start  <= 1'b0;
                pointer     <= next_ptr;
                arb_busy    <= 1'b0;
                state       <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter: vector table, corner sequences, random run.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the bench plays uart_tx, answering start with busy then a done pulse.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [1:0]  owner;
    logic        arb_busy;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_busy;
    logic        uart_done;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .owner       (owner),
        .arb_busy    (arb_busy),
        .uart_start  (uart_start),
        .uart_data   (uart_data),
        .uart_busy   (uart_busy),
        .uart_done   (uart_done),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_idx;
        int          delay;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: first set request at or after ptr, wrapping.
    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    task automatic check_grant(input int idx, input logic [7:0] b);
        check("grant", grant, 32'(1 << idx));
        check("owner", owner, idx);
        check("uart_data", uart_data, b);
        check("arb_busy_set", arb_busy, 1);
        check("done_quiet", done, 0);
    endtask

    // Called right after the grant sample; plays uart_tx through one byte.
    task automatic finish_byte(input int idx, input int delay);
        uart_done = 1'b1;              // stray done while in START must be ignored
        step();
        uart_done = 1'b0;
        check("start_high", uart_start, 1);
        check("stray_done_ignored", done, 0);
        uart_busy = 1'b1;
        step();
        check("start_drop", uart_start, 0);
        for (int k = 0; k < delay; k++) begin
            step();
            check("no_early_done", done, 0);
        end
        uart_done = 1'b1;
        uart_busy = 1'b0;
        step();
        check("done_pulse", done, 32'(1 << idx));
        check("arb_busy_clear", arb_busy, 0);
        uart_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        logic [31:0] d;
        int m_ptr, m_owner, w;
        logic m_free, prev_granted, emu_busy, done_real;
        logic [7:0] m_data;
        logic [3:0] prev_req, exp_grant, exp_done;
        logic [31:0] prev_data;
        int emu_cnt;

        vecs[0] = '{4'b0010, 32'h1122FF33, 1, 0};
        vecs[1] = '{4'b1001, 32'hA5000C5A, 3, 2};
        vecs[2] = '{4'b1001, 32'h3C00007E, 0, 1};
        vecs[3] = '{4'b0110, 32'h00818200, 1, 0};
        vecs[4] = '{4'b0110, 32'h00818200, 2, 3};
        vecs[5] = '{4'b1001, 32'hDE0000AD, 3, 0};
        vecs[6] = '{4'b1001, 32'hDE0000AD, 0, 1};
        vecs[7] = '{4'b1000, 32'h01000000, 3, 0};

        req = '0; req_data = '0; uart_busy = 1'b0; uart_done = 1'b0;
        do_reset();
        step();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_start", uart_start, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_data", uart_data, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout", timeout_err, 0);

        // Vector table: one full byte per row, pointer carried from row to row.
        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            req_data = vecs[i].data;
            step();
            d = vecs[i].data;
            check_grant(vecs[i].exp_idx, lane(d, vecs[i].exp_idx));
            req = '0;
            finish_byte(vecs[i].exp_idx, vecs[i].delay);
        end

        // Contention with back-to-back service: exactly one IDLE cycle between bytes.
        req = 4'b1111;
        req_data = 32'h44332211;
        step();
        check_grant(0, 8'h11);
        for (int n = 1; n <= 4; n++) begin
            finish_byte((n - 1) % 4, n);
            step();
            check_grant(n % 4, lane(32'h44332211, n % 4));
        end
        req = '0;
        finish_byte(0, 1);

        // Reset mid-byte: pointer (now 1) must return to 0, no done for the lost byte.
        req = 4'b0100;
        req_data = 32'h00C30000;
        step();
        check_grant(2, 8'hC3);
        uart_busy = 1'b1;
        step();
        req = '0;
        step();
        reset = 1'b0;
        step();
        check("mid_rst_grant", grant, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_start", uart_start, 0);
        check("mid_rst_busy", arb_busy, 0);
        check("mid_rst_data", uart_data, 0);
        check("mid_rst_owner", owner, 0);
        reset = 1'b1;
        uart_busy = 1'b0;
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
        check("idle_done_ignored", done, 0);
        req = 4'b1111;
        req_data = 32'h04030201;
        step();
        check_grant(0, 8'h01);
        req = '0;
        finish_byte(0, 0);

`ifdef UART_ARB_TIMEOUT_EN
        do_reset();
        req = 4'b0011;
        req_data = 32'h0000B2B1;
        step();
        check_grant(0, 8'hB1);
        for (int k = 1; k < TIMEOUT_CYC; k++) begin
            step();
            check("wd_quiet", timeout_err, 0);
            check("wd_start_held", uart_start, 1);
        end
        step();
        check("wd_fire", timeout_err, 1);
        check("wd_no_done", done, 0);
        check("wd_start_drop", uart_start, 0);
        check("wd_busy_clear", arb_busy, 0);
        step();
        check_grant(1, 8'hB2);
        req = '0;
        finish_byte(1, 2);
`endif

        // Randomized run against a transaction-level model.
        do_reset();
        m_ptr = 0; m_owner = 0; m_data = '0; m_free = 1'b1;
        prev_req = '0; prev_data = '0; prev_granted = 1'b0;
        emu_busy = 1'b0; emu_cnt = 0; done_real = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            exp_grant = '0;
            exp_done = '0;
            if (m_free && prev_req != '0) begin
                w = pick(prev_req, m_ptr);
                exp_grant = 4'(1 << w);
                m_free = 1'b0;
                m_owner = w;
                m_data = lane(prev_data, w);
            end
            if (done_real) begin
                exp_done = 4'(1 << m_owner);
                m_free = 1'b1;
                m_ptr = (m_owner + 1) % NUM_REQ;
            end
            check("rnd_grant", grant, exp_grant);
            check("rnd_done", done, exp_done);
            check("rnd_start", uart_start, prev_granted);
            check("rnd_arb_busy", arb_busy, !m_free);
            check("rnd_owner", owner, m_owner);
            check("rnd_data", uart_data, m_data);
            check("rnd_timeout", timeout_err, 0);
            prev_granted = (exp_grant != '0);

            done_real = 1'b0;
            if (uart_start) begin
                uart_busy = 1'b1;
                uart_done = 1'b0;
                emu_busy = 1'b1;
                emu_cnt = $urandom_range(1, 6);
            end else if (emu_busy) begin
                emu_cnt--;
                if (emu_cnt == 0) begin
                    uart_done = 1'b1;
                    uart_busy = 1'b0;
                    emu_busy = 1'b0;
                    done_real = 1'b1;
                end else begin
                    uart_done = 1'b0;
                end
            end else begin
                uart_busy = 1'b0;
                uart_done = ($urandom_range(0, 7) == 0);
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) req[i] = 1'b0;
                else if (req[i]) req[i] = ($urandom_range(0, 19) != 0);
                else req[i] = ($urandom_range(0, 3) == 0);
            end
            req_data = $urandom;
            prev_req = req;
            prev_data = req_data;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
